// File: rtl/sram_64x128_bw.sv
// sram_64x128_bw: single-port 64x128 SRAM, active-low bit write mask, registered read-before-write Q.
module sram_64x128_bw #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CEN,
  input  logic                  WEN,
  input  logic [DATA_WIDTH-1:0] BWEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] wr_d;
  assign wr_d = (D & ~BWEN) | (mem_q[A] & BWEN);
  assign Q = q_q;
  // Q samples the pre-write word, so a write returns the old contents
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!CEN) begin
      q_q <= mem_q[A];
      if (!WEN) mem_q[A] <= wr_d;
    end
  end
`ifndef SYNTHESIS
  a_depth: assert property (@(posedge clk) DEPTH == (1 << ADDR_WIDTH));
  a_ctrl_known: assert property (@(posedge clk) rst_n |-> !$isunknown({CEN, WEN}));
`endif
endmodule

// File: tb/tb_sram_64x128_bw.sv
// tb_sram_64x128_bw: directed test-plan steps plus random traffic checked against an array model.
module tb_sram_64x128_bw;
  logic         clk = 1'b0;
  logic         rst_n, cen, wen;
  logic [127:0] bwen, d, q;
  logic [5:0]   a;
  logic [127:0] ref_mem [64];
  logic [127:0] ref_q;
  int           n_vec = 0;
  int           n_bad = 0;
  sram_64x128_bw dut (
    .clk(clk), .rst_n(rst_n), .CEN(cen), .WEN(wen), .BWEN(bwen), .A(a), .D(d), .Q(q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic r, input logic c, input logic w, input logic [127:0] bw,
                      input logic [5:0] ad, input logic [127:0] dd, input string tag);
    @(negedge clk);
    rst_n = r; cen = c; wen = w; bwen = bw; a = ad; d = dd;
    @(posedge clk);
    if (!r) begin
      ref_q = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    end else if (!c) begin
      ref_q = ref_mem[ad];
      if (!w) ref_mem[ad] = (dd & ~bw) | (ref_mem[ad] & bw);
    end
    #1 chk(tag, q, ref_q);
  endtask
  initial begin
    logic [127:0] v, m;
    rst_n = 1'b0; cen = 1'b1; wen = 1'b1; bwen = '1; a = '0; d = '0;
    ref_q = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    step(1'b0, 1'b0, 1'b0, '0, 6'h00, '1, "reset");
    chk("reset_q", q, 128'h0);
    step(1'b1, 1'b0, 1'b1, '0, 6'h00, '1, "rd0");
    chk("rd0_zero", q, 128'h0);
    step(1'b1, 1'b0, 1'b1, '0, 6'h3F, '1, "rd3f");
    chk("rd3f_zero", q, 128'h0);
    v = 128'h0123456789ABCDEF_FEDCBA9876543210;
    step(1'b1, 1'b0, 1'b0, '0, 6'h05, v, "wr5");
    chk("wr5_old", q, 128'h0);
    step(1'b1, 1'b0, 1'b1, '1, 6'h05, '0, "rd5");
    chk("rd5_new", q, v);
    step(1'b1, 1'b0, 1'b0, '0, 6'h10, '1, "pre10");
    m = ~(128'hFF << 8);
    step(1'b1, 1'b0, 1'b0, m, 6'h10, '0, "mask10");
    chk("mask10_old", q, '1);
    step(1'b1, 1'b0, 1'b1, '0, 6'h10, '0, "rd10");
    chk("rd10_masked", q, {{112{1'b1}}, 8'h00, 8'hFF});
    step(1'b1, 1'b1, 1'b0, '0, 6'h10, '0, "cen_off");
    chk("cen_off_hold", q, {{112{1'b1}}, 8'h00, 8'hFF});
    step(1'b1, 1'b0, 1'b1, '0, 6'h3F, '0, "rd3f_b");
    step(1'b1, 1'b0, 1'b1, '0, 6'h10, '0, "rd10_b");
    chk("rd10_after_cen", q, {{112{1'b1}}, 8'h00, 8'hFF});
    step(1'b1, 1'b0, 1'b0, '1, 6'h05, '0, "noop_wr");
    chk("noop_wr_q", q, v);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i);
      step(1'b1, 1'b0, 1'b0, '0, 6'(i), {16{b}}, "stream_wr");
    end
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i);
      step(1'b1, 1'b0, 1'b1, '0, 6'(i), '0, "stream_rd");
      chk("stream_idx", q, {16{b}});
    end
    step(1'b0, 1'b0, 1'b0, '0, 6'h20, '1, "rst_wr20");
    chk("rst_wr20_q", q, 128'h0);
    step(1'b1, 1'b0, 1'b1, '0, 6'h20, '0, "rd20");
    chk("rd20_zero", q, 128'h0);
    for (int n = 0; n < 400; n++) begin
      logic r, c, w;
      logic [127:0] bw, dd;
      r = ($urandom_range(0, 49) != 0);
      c = ($urandom_range(0, 7) == 0);
      w = $urandom_range(0, 1) == 1;
      dd = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 3))
        0: bw = '0;
        1: bw = '1;
        default: bw = {$urandom, $urandom, $urandom, $urandom};
      endcase
      step(r, c, w, bw, 6'($urandom_range(0, 7)), dd, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
